// File: rtl/phasedet_pkg.sv
// Shared types, default parameters and the period tolerance check for
// the phase-enable sequencer.
package phasedet_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      VERIFY  = 2'd2,
      LOCKED  = 2'd3
   } pd_state_e;

   localparam int NPHASE_DEF      = 4;
   localparam int CNT_W_DEF       = 8;
   localparam int TOL_DEF         = 2;
   localparam int LOCK_CYCLES_DEF = 4;
   localparam int TIMEOUT_DEF     = 200;

   function automatic logic in_tol(input int unsigned a,
                                   input int unsigned b,
                                   input int unsigned tol);
      int unsigned diff;
      diff = (a >= b) ? (a - b) : (b - a);
      return (diff <= tol);
   endfunction

endpackage

// File: rtl/en_sync.sv
// Two-flop synchroniser for one asynchronous level input.
module en_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/phase_enable_seq.sv
// Power-clock period tracker and one-hot phase enable generator.
// Optional build macro PHASEDET_FAULT_EN adds En/EnBar complementarity checking.
module phase_enable_seq
   import phasedet_pkg::*;
#(
   parameter int NPHASE      = NPHASE_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TOL         = TOL_DEF,
   parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       En,
   input  logic                       EnBar,
   input  logic                       clr_err,
   output logic [NPHASE-1:0]          phase_en,
   output logic [$clog2(NPHASE)-1:0]  phase_idx,
   output logic                       locked,
   output logic [CNT_W-1:0]           period,
   output logic                       err
);

   localparam int IDX_W  = $clog2(NPHASE);
   localparam int GOOD_W = $clog2(LOCK_CYCLES + 1);

   pd_state_e         state_q, state_d;
   logic              en_s;
   logic              en_prev_q;
   logic              edge_d, edge_q;
   logic              fault;
   logic              tmo;
   logic              match;
   logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0]  ref_q, ref_d;
   logic [CNT_W-1:0]  slot_q, slot_d;
   logic [CNT_W-1:0]  slot_len;
   logic [GOOD_W-1:0] good_q, good_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   en_sync u_sync_en (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (En),
      .q_o   (en_s)
   );

`ifdef PHASEDET_FAULT_EN
   logic enbar_s;
   logic same_q;
   logic err_q, err_d;

   en_sync u_sync_enbar (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (EnBar),
      .q_o   (enbar_s)
   );

   // A fault needs the synchronised pair equal on two consecutive clocks.
   assign fault  = (en_s == enbar_s) && same_q;
   assign edge_d = en_s && !en_prev_q && !enbar_s;
   assign err_d  = fault ? 1'b1 : (clr_err ? 1'b0 : err_q);
   assign err    = err_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         same_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         same_q <= (en_s == enbar_s);
         err_q  <= err_d;
      end
   end
`else
   logic unused_inputs;

   assign unused_inputs = EnBar ^ clr_err;
   assign fault         = 1'b0;
   assign edge_d        = en_s && !en_prev_q;
   assign err           = 1'b0;
`endif

   assign tmo      = (per_cnt_q >= CNT_W'(TIMEOUT));
   assign slot_len = ref_q >> IDX_W;
   // A zero slot length cannot sequence phases, so such a period never matches.
   assign match    = in_tol(32'(per_cnt_q), 32'(ref_q), TOL) && (slot_len != '0);

   always_comb begin
      per_cnt_d = per_cnt_q;
      if (edge_q) begin
         per_cnt_d = CNT_W'(1);
      end else if (per_cnt_q != {CNT_W{1'b1}}) begin
         per_cnt_d = per_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      good_d  = good_q;
      case (state_q)
         SEARCH: begin
            if (edge_q) state_d = MEASURE;
         end
         MEASURE: begin
            if (edge_q) begin
               ref_d   = per_cnt_q;
               good_d  = '0;
               state_d = VERIFY;
            end else if (tmo) begin
               state_d = SEARCH;
            end
         end
         VERIFY: begin
            if (edge_q) begin
               if (match) begin
                  good_d = good_q + 1'b1;
                  if (good_q == GOOD_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
               end else begin
                  ref_d  = per_cnt_q;
                  good_d = '0;
               end
            end else if (tmo) begin
               state_d = SEARCH;
            end
         end
         LOCKED: begin
            if (edge_q) begin
               if (!match) state_d = SEARCH;
            end else if (tmo) begin
               state_d = SEARCH;
            end
         end
         default: state_d = SEARCH;
      endcase
      if (fault) state_d = SEARCH;
      if (state_d == SEARCH) begin
         ref_d  = '0;
         good_d = '0;
      end
   end

   // Phase slots only run while lock is held; any edge realigns them.
   always_comb begin
      slot_d = '0;
      idx_d  = '0;
      if ((state_q == LOCKED) && (state_d == LOCKED) && !edge_q) begin
         if (slot_q == (slot_len - CNT_W'(1))) begin
            slot_d = '0;
            idx_d  = (idx_q != IDX_W'(NPHASE - 1)) ? (idx_q + 1'b1) : idx_q;
         end else begin
            slot_d = slot_q + 1'b1;
            idx_d  = idx_q;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= SEARCH;
         en_prev_q <= 1'b0;
         edge_q    <= 1'b0;
         per_cnt_q <= '0;
         ref_q     <= '0;
         good_q    <= '0;
         slot_q    <= '0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         en_prev_q <= en_s;
         edge_q    <= edge_d;
         per_cnt_q <= per_cnt_d;
         ref_q     <= ref_d;
         good_q    <= good_d;
         slot_q    <= slot_d;
         idx_q     <= idx_d;
      end
   end

   assign locked    = (state_q == LOCKED);
   assign phase_idx = idx_q;
   assign phase_en  = locked ? (NPHASE'(1) << idx_q) : '0;
   assign period    = locked ? ref_q : '0;

endmodule

// File: doc/phase_enable_seq.md
# phase_enable_seq

Digital consumer of the phase detector's buffered `En`/`EnBar` pair. It synchronises the pair into the logic clock domain and measures the adiabatic power-clock period. After confirming a stable period, it emits a one-hot per-phase enable vector that gates downstream pipeline-stage control in the MIPS25 adiabatic datapath. A lock/lost FSM keeps stage enables quiet whenever the power clock is absent, unstable or non-complementary.

## Interface
- `NPHASE`, 4: power-clock phases per cycle; power of 2, ≥2.
- `CNT_W`, 8: period/slot counter width.
- `TOL`, 2: accepted period deviation, ±clocks.
- `LOCK_CYCLES`, 4: consecutive matching periods required to lock.
- `TIMEOUT`, 200: clocks without an `En` rising edge before lock is lost; must be ≤ 2^CNT_W−1.

Ports:
- `CLK`  in  1  logic clock.
- `RST`  in  1  asynchronous, active-high reset.
- `En`  in  1  phase-detector enable, asynchronous.
- `EnBar`  in  1  complement of `En`, asynchronous.
- `clr_err`  in  1  clears sticky `err`.
- `phase_en`  out  NPHASE  one-hot enable of current phase; all-zero unless locked.
- `phase_idx`  out  $clog2(NPHASE)  current phase index.
- `locked`  out  1  period stable, enables valid.
- `period`  out  CNT_W  locked reference period, in clocks.
- `err`  out  1  sticky complementarity fault.

## Operation
- `En` and `EnBar` each pass through a 2-flop synchroniser (`En_s`, `EnBar_s`).
- Edge: `En_s` 0→1 while `EnBar_s`=0.
- `per_cnt` counts clocks since the last edge, saturating at 2^CNT_W−1. It resets to 1 on an edge.
- `tmo`: `per_cnt` reaches TIMEOUT.
- FSM states and transitions:
  - SEARCH: edge → MEASURE.
  - MEASURE: edge → capture `ref`=`per_cnt`, good=0, go to VERIFY.
  - VERIFY: edge with |`per_cnt`−`ref`|≤TOL → good+1; reaching LOCK_CYCLES → LOCKED. Edge with a mismatch → `ref`=`per_cnt`, good=0, stay in VERIFY.
  - LOCKED: matching edge → stay and realign. Mismatch → SEARCH.
  - Any state except SEARCH: `tmo` or fault → SEARCH.
- `slot_len` = `ref` >> log2(NPHASE). If `slot_len`=0, every VERIFY edge counts as a mismatch, so the block never locks.
- In LOCKED, a slot counter advances `phase_idx` each `slot_len` clocks. `phase_idx` saturates at NPHASE−1. Each edge resets `phase_idx` and the slot counter to 0.
- `phase_en` = one-hot(`phase_idx`) when `locked`, else 0.
- `period` holds `ref` while locked and reads 0 otherwise.
- Simultaneous events:
  - Edge and `tmo` in the same cycle: the edge wins.
  - Fault and edge in the same cycle: the fault wins.
  - `clr_err` and a new fault in the same cycle: `err` stays 1.

## Timing
- Reset values: all outputs 0, FSM in SEARCH, all counters 0.
- Input to edge detection: 3 clocks (2 synchroniser clocks plus 1 edge-register clock).
- `locked` rises on the clock after the LOCK_CYCLES-th matching edge is detected.
- `locked` falls, and `phase_en` goes to 0, on the clock after a mismatch, `tmo` or fault.
- `RST` mid-operation clears everything immediately (asynchronous). Resynchronisation restarts from SEARCH.

## Configuration
- `PHASEDET_FAULT_EN` defined: `En_s`==`EnBar_s` for ≥2 consecutive clocks sets `err` (sticky) and counts as a fault.
- `PHASEDET_FAULT_EN` undefined:
  - `EnBar` is unused and its synchroniser is omitted.
  - `err` is tied to 0 and `clr_err` is ignored.
  - The edge condition is `En_s` 0→1 alone.

## Structure
- `phasedet_pkg`:
  - state enum (SEARCH, MEASURE, VERIFY, LOCKED);
  - default parameter constants;
  - the `in_tol(a,b,tol)` function.
- Sub-module `en_sync`: 2-flop synchroniser with async active-high reset, instanced once per input.

## Test plan
Bench settings: NPHASE=4, TOL=2, LOCK_CYCLES=4, TIMEOUT=200.
- Steady `En` period of 64 clocks, 50% duty, `EnBar`=~`En`:
  - `locked`=1 one clock after the 6th edge is detected; `period`=64;
  - `phase_en` steps 0001→0010→0100→1000, 16 clocks each, realigning at every edge.
- Locked, then periods of 66, 62, 67:
  - 66 and 62 keep lock;
  - 67 drops `locked` and `phase_en` to 0 on the next clock and returns the FSM to SEARCH.
- Locked, then `En` held low: `locked` drops 200 clocks after the last edge.
- `PHASEDET_FAULT_EN` defined, `En`=`EnBar`=1 for 3 clocks:
  - `err`=1 and `locked`=0;
  - `clr_err` pulse → `err`=0;
  - `clr_err` coincident with a persisting fault → `err` stays 1.
- Period of 3 clocks (`slot_len`=0) for 20 cycles: `locked` never asserts; `phase_en` stays 0.
- `RST` pulse while locked:
  - all outputs read 0 in the same cycle;
  - relock occurs after 6 further edges.
